parse_top: RTL and testbench
============================

# parse_top

Zero-padding feature-map parser. It holds 16 input channels in 16 independent on-chip buffer banks that are loaded through a host write port. On a start command it streams the spatially zero-padded frame out, one pixel position per clock. All 16 channels are presented in parallel on byte-wide outputs. It sits between the host/DMA loader and the convolution datapath.

## Interface
Parameters:
- IMG_W, 64, frame width in pixels; must be a multiple of 16.
- IMG_H, 32, frame height in rows; IMG_W*IMG_H/16 must be ≤ 512.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rstn  in  1  synchronous, active-high reset: a 1 sampled on a rising clk edge resets the block.
- iStart  in  1  start command; level input, acted on at its rising edge.
- i_ena  in  16  per-bank write-port enable (bit b = bank b).
- i_wea  in  16  per-bank write enable.
- i_addra  in  9  write word address (0..511).
- i_dia  in  128  write data: 16 pixels, byte lane L = bits [8L+7:8L].
- oDin0..oDin15  out  8 each  padded pixel of channel 0..15.
- oValid  out  1  oDin* carry a pixel position this cycle.
- oDone  out  1  one-cycle pulse coincident with the last pixel.

## Operation
- **Banks:** 16 banks, each 512 × 128 bit. Contents are not reset.
- **Write:** on a clk edge with i_ena[b] & i_wea[b] = 1, write i_dia to bank b at i_addra.
  - Any combination of banks may be written in the same cycle.
  - Writes are accepted in any state, including during a scan.
  - A same-cycle read/write collision on one address returns the old word (read-first).
- **Pixel layout:** pixel index p = y*IMG_W + x (x, y zero-based). It is stored at word p>>4, byte lane p[3:0].
- **States:**
  - IDLE → RUN when iStart = 1 and iStart was 0 on the previous edge (registered edge detect).
  - iStart edges during RUN are ignored.
  - A held-high iStart does not restart the scan.
- **RUN:** raster-scan padded coordinates (r, c) with r = 0..IMG_H+1 and c = 0..IMG_W+1, column fastest, starting at (0,0).
  - Border positions (r = 0, r = IMG_H+1, c = 0, c = IMG_W+1): every oDin = 0x00, oValid = 1.
  - Interior positions: use p = (r−1)*IMG_W + (c−1). oDin_b = byte lane p[3:0] of bank b word p>>4.
- **End of scan:** after issuing (IMG_H+1, IMG_W+1), return to IDLE. The outputs drain the 2-stage pipeline.
- When oValid = 0, all oDin* = 0x00.
- Total outputs per scan: (IMG_W+2)*(IMG_H+2) = 2244 with defaults.

## Timing
- **Reset:** oDin* = 0, oValid = 0, oDone = 0, state IDLE, counters 0, iStart edge register 0.
  - Reset mid-scan aborts the scan immediately.
  - The pipeline is flushed, and no oValid is seen after the reset edge.
- **Start latency:** iStart sampled rising at edge E gives RUN from E. Coordinate (0,0) is issued in the cycle after E.
- **Pipeline:** 2 registered stages, bank read then output register.
  - The pixel for the coordinate issued in cycle k is on oDin* / oValid in cycle k+2.
  - First oValid is 2 cycles after RUN entry.
- **Throughput:** one position per cycle, no bubbles. oValid is high for exactly 2244 consecutive cycles.
- **oDone:** high only in the cycle carrying position (IMG_H+1, IMG_W+1).
- **Restart:** a new iStart rising edge is accepted once the state is back in IDLE, which may be before the pipeline drains. Back-to-back scans are then contiguous.

## Test plan
- **Reset:** hold rstn = 1 for 3 cycles, including mid-scan → all outputs 0 on the next edge; no oValid until a new iStart rise.
- **Load and scan:** load all 16 banks at addresses 0..127, bank k word = 0x4k3k2k1k in the low 32 bits (e.g. bank 0: 0x40302010, bank 15: 0x4F3F2F1F). Raise iStart and hold it high.
  - First 67 valid outputs (row 0 and column 0 of row 1) are all 0x00.
  - At (1,1): oDin0 = 0x10, oDin15 = 0x1F.
  - At (1,2): 0x20 / 0x2F.
  - At (1,3): 0x30 / 0x3F.
  - At (1,4): 0x40 / 0x4F.
  - At (1,5)..(1,16): 0x00.
  - At (1,17): 0x10 / 0x1F again.
- **Count and done:** oValid high for exactly 2244 consecutive cycles; oDone high only on the last one. Holding iStart high produces no second scan.
- **Restart:** drop iStart, raise it again → an identical second scan; an iStart pulse mid-scan has no effect.
- **Write-enable gating:** i_ena = 0x0001 with i_wea = 0 → bank 0 unchanged. i_wea = 0x0003 with i_ena = 0x0001 → only bank 0 written.
- **Addressing:** write a distinct byte at bank 3, address 127, lane 15 → it appears on oDin3 at padded position (32,64), the last interior pixel.

Source files
------------

// File: rtl/parse_top.sv
// Zero-padding feature-map parser: 16 channel banks loaded by the host, streamed
// out as a zero-bordered raster frame through a two-stage (read, output) pipeline.
module parse_top #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         iStart,
    input  logic [15:0]  i_ena,
    input  logic [15:0]  i_wea,
    input  logic [8:0]   i_addra,
    input  logic [127:0] i_dia,
    output logic [7:0]   oDin0,
    output logic [7:0]   oDin1,
    output logic [7:0]   oDin2,
    output logic [7:0]   oDin3,
    output logic [7:0]   oDin4,
    output logic [7:0]   oDin5,
    output logic [7:0]   oDin6,
    output logic [7:0]   oDin7,
    output logic [7:0]   oDin8,
    output logic [7:0]   oDin9,
    output logic [7:0]   oDin10,
    output logic [7:0]   oDin11,
    output logic [7:0]   oDin12,
    output logic [7:0]   oDin13,
    output logic [7:0]   oDin14,
    output logic [7:0]   oDin15,
    output logic         oValid,
    output logic         oDone
);

    localparam int RW = $clog2(IMG_H + 2);
    localparam int CW = $clog2(IMG_W + 2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          start_prev_q, start_prev_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    logic          s1_valid_q, s1_valid_d;
    logic          s1_border_q, s1_border_d;
    logic          s1_last_q, s1_last_d;
    logic [3:0]    s1_lane_q, s1_lane_d;

    logic [7:0]    dout_q [16];
    logic [7:0]    dout_d [16];
    logic          valid_q, valid_d;
    logic          done_q, done_d;

    logic          issue;
    logic          last_pos;
    logic          border;
    logic [RW-1:0] row_m1;
    logic [CW-1:0] col_m1;
    logic [8:0]    rd_addr;
    logic [127:0]  rd_data [16];

    assign issue    = (state_q == ST_RUN);
    assign last_pos = issue && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign border   = (row_q == '0) || (row_q == ROW_LAST) || (col_q == '0) || (col_q == COL_LAST);
    assign row_m1   = row_q - RW'(1);
    assign col_m1   = col_q - CW'(1);
    // IMG_W is a multiple of 16, so each row starts on a word boundary.
    assign rd_addr  = 9'(int'(row_m1) * (IMG_W / 16)) + 9'(col_m1 >> 4);

    always_comb begin
        start_prev_d = iStart;
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        case (state_q)
            ST_IDLE: begin
                if (iStart && !start_prev_q) begin
                    state_d = ST_RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_RUN: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1_valid_d  = issue;
        s1_border_d = border;
        s1_last_d   = last_pos;
        s1_lane_d   = col_m1[3:0];
        valid_d     = s1_valid_q;
        done_d      = s1_valid_q && s1_last_q;
        for (int b = 0; b < 16; b++) begin
            dout_d[b] = (s1_valid_q && !s1_border_q) ? rd_data[b][{s1_lane_q, 3'b000} +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_border_q  <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_lane_q    <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            for (int b = 0; b < 16; b++) begin
                dout_q[b] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            row_q        <= row_d;
            col_q        <= col_d;
            s1_valid_q   <= s1_valid_d;
            s1_border_q  <= s1_border_d;
            s1_last_q    <= s1_last_d;
            s1_lane_q    <= s1_lane_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            for (int b = 0; b < 16; b++) begin
                dout_q[b] <= dout_d[b];
            end
        end
    end

    // Banks are unreset RAMs; the read register samples the old word on a collision.
    for (genvar gb = 0; gb < 16; gb++) begin : g_bank
        logic [127:0] mem [512];
        logic [127:0] rd_word_q;

        always_ff @(posedge clk) begin
            if (i_ena[gb] && i_wea[gb]) begin
                mem[i_addra] <= i_dia;
            end
            rd_word_q <= mem[rd_addr];
        end

        assign rd_data[gb] = rd_word_q;
    end

    assign oDin0  = dout_q[0];
    assign oDin1  = dout_q[1];
    assign oDin2  = dout_q[2];
    assign oDin3  = dout_q[3];
    assign oDin4  = dout_q[4];
    assign oDin5  = dout_q[5];
    assign oDin6  = dout_q[6];
    assign oDin7  = dout_q[7];
    assign oDin8  = dout_q[8];
    assign oDin9  = dout_q[9];
    assign oDin10 = dout_q[10];
    assign oDin11 = dout_q[11];
    assign oDin12 = dout_q[12];
    assign oDin13 = dout_q[13];
    assign oDin14 = dout_q[14];
    assign oDin15 = dout_q[15];
    assign oValid = valid_q;
    assign oDone  = done_q;

endmodule

// File: tb/tb_parse_top.sv
// Directed bench for parse_top: loads the banks, runs padded scans and checks
// hand-computed pixels, counts, oDone, restart, write gating and reset abort.
module tb_parse_top;

    logic         clk = 1'b0;
    logic         rstn;
    logic         iStart;
    logic [15:0]  i_ena;
    logic [15:0]  i_wea;
    logic [8:0]   i_addra;
    logic [127:0] i_dia;
    logic [7:0]   oDin0, oDin1, oDin2, oDin3, oDin4, oDin5, oDin6, oDin7;
    logic [7:0]   oDin8, oDin9, oDin10, oDin11, oDin12, oDin13, oDin14, oDin15;
    logic         oValid;
    logic         oDone;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] cap0 [3000];
    logic [7:0] cap1 [3000];
    logic [7:0] cap3 [3000];
    logic [7:0] cap15 [3000];
    logic [7:0] ref0 [3000];
    logic [7:0] ref3 [3000];
    logic [7:0] ref15 [3000];

    parse_top dut (
        .clk(clk), .rstn(rstn), .iStart(iStart),
        .i_ena(i_ena), .i_wea(i_wea), .i_addra(i_addra), .i_dia(i_dia),
        .oDin0(oDin0), .oDin1(oDin1), .oDin2(oDin2), .oDin3(oDin3),
        .oDin4(oDin4), .oDin5(oDin5), .oDin6(oDin6), .oDin7(oDin7),
        .oDin8(oDin8), .oDin9(oDin9), .oDin10(oDin10), .oDin11(oDin11),
        .oDin12(oDin12), .oDin13(oDin13), .oDin14(oDin14), .oDin15(oDin15),
        .oValid(oValid), .oDone(oDone)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_write(input logic [15:0] ena, input logic [15:0] wea,
                               input logic [8:0] addr, input logic [127:0] data);
        i_ena   = ena;
        i_wea   = wea;
        i_addra = addr;
        i_dia   = data;
        @(negedge clk);
        i_ena   = 16'h0;
        i_wea   = 16'h0;
    endtask

    task automatic capture_scan(input bit mid_pulse, output int n_valid, output int done_idx, output int done_cnt);
        int wait_cnt;
        wait_cnt = 0;
        n_valid  = 0;
        done_idx = -1;
        done_cnt = 0;
        while (!oValid && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        while (oValid && n_valid < 3000) begin
            cap0[n_valid]  = oDin0;
            cap1[n_valid]  = oDin1;
            cap3[n_valid]  = oDin3;
            cap15[n_valid] = oDin15;
            if (oDone) begin
                done_idx = n_valid;
                done_cnt++;
            end
            if (mid_pulse) begin
                if (n_valid == 500) iStart = 1'b0;
                if (n_valid == 502) iStart = 1'b1;
                if (n_valid == 504) iStart = 1'b0;
            end
            n_valid++;
            @(negedge clk);
        end
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (oValid) n++;
        end
    endtask

    initial begin
        int n_valid, done_idx, done_cnt, nz, diff, stray;
        logic [3:0] kk;
        logic [7:0] all_or;

        rstn    = 1'b1;
        iStart  = 1'b0;
        i_ena   = 16'h0;
        i_wea   = 16'h0;
        i_addra = 9'h0;
        i_dia   = 128'h0;
        repeat (3) @(negedge clk);

        all_or = oDin0 | oDin1 | oDin2 | oDin3 | oDin4 | oDin5 | oDin6 | oDin7 |
                 oDin8 | oDin9 | oDin10 | oDin11 | oDin12 | oDin13 | oDin14 | oDin15;
        check_output("reset_valid", 32'(oValid), 32'h0);
        check_output("reset_done", 32'(oDone), 32'h0);
        check_output("reset_din", 32'(all_or), 32'h0);
        rstn = 1'b0;
        @(negedge clk);

        $display("[TB] loading banks");
        for (int k = 0; k < 16; k++) begin
            kk = 4'(k);
            for (int a = 0; a < 128; a++) begin
                apply_write(16'(1 << k), 16'(1 << k), 9'(a),
                            {96'h0, 4'h4, kk, 4'h3, kk, 4'h2, kk, 4'h1, kk});
            end
        end
        apply_write(16'h0008, 16'h0008, 9'd127, {8'hA5, 88'h0, 32'h43332313});
        apply_write(16'h0001, 16'h0000, 9'd100, {16{8'hEE}});
        apply_write(16'h0001, 16'h0003, 9'd101, {16{8'h77}});

        $display("[TB] scan 1, iStart held high");
        iStart = 1'b1;
        capture_scan(1'b0, n_valid, done_idx, done_cnt);
        check_output("scan1_count", 32'(n_valid), 32'd2244);
        check_output("scan1_done_idx", 32'(done_idx), 32'd2243);
        check_output("scan1_done_cnt", 32'(done_cnt), 32'd1);
        nz = 0;
        for (int i = 0; i < 67; i++) if (cap0[i] != 8'h00 || cap15[i] != 8'h00) nz++;
        check_output("top_border_zero", 32'(nz), 32'd0);
        check_output("p1_1_b0", 32'(cap0[67]), 32'h10);
        check_output("p1_1_b15", 32'(cap15[67]), 32'h1F);
        check_output("p1_1_b3", 32'(cap3[67]), 32'h13);
        check_output("p1_2_b0", 32'(cap0[68]), 32'h20);
        check_output("p1_2_b15", 32'(cap15[68]), 32'h2F);
        check_output("p1_3_b0", 32'(cap0[69]), 32'h30);
        check_output("p1_3_b15", 32'(cap15[69]), 32'h3F);
        check_output("p1_4_b0", 32'(cap0[70]), 32'h40);
        check_output("p1_4_b15", 32'(cap15[70]), 32'h4F);
        nz = 0;
        for (int i = 71; i <= 82; i++) if (cap0[i] != 8'h00 || cap15[i] != 8'h00) nz++;
        check_output("p1_5_16_zero", 32'(nz), 32'd0);
        check_output("p1_17_b0", 32'(cap0[83]), 32'h10);
        check_output("p1_17_b15", 32'(cap15[83]), 32'h1F);
        check_output("right_border_b15", 32'(cap15[131]), 32'h00);
        check_output("left_border_r2_b15", 32'(cap15[132]), 32'h00);
        check_output("gate_wea0_b0", 32'(cap0[1717]), 32'h10);
        check_output("gate_ena_b0", 32'(cap0[1733]), 32'h77);
        check_output("gate_ena_b1", 32'(cap1[1733]), 32'h11);
        check_output("last_pix_b3", 32'(cap3[2176]), 32'hA5);
        check_output("last_pix_b0", 32'(cap0[2176]), 32'h00);
        check_output("lane14_b3", 32'(cap3[2175]), 32'h00);
        check_output("bottom_border_b3", 32'(cap3[2243]), 32'h00);
        for (int i = 0; i < 2244; i++) begin
            ref0[i]  = cap0[i];
            ref3[i]  = cap3[i];
            ref15[i] = cap15[i];
        end
        count_valid(50, stray);
        check_output("held_no_rescan", 32'(stray), 32'd0);

        $display("[TB] scan 2 with mid-scan iStart pulse");
        iStart = 1'b0;
        @(negedge clk);
        iStart = 1'b1;
        capture_scan(1'b1, n_valid, done_idx, done_cnt);
        check_output("scan2_count", 32'(n_valid), 32'd2244);
        check_output("scan2_done_idx", 32'(done_idx), 32'd2243);
        check_output("scan2_done_cnt", 32'(done_cnt), 32'd1);
        diff = 0;
        for (int i = 0; i < 2244; i++)
            if (cap0[i] !== ref0[i] || cap3[i] !== ref3[i] || cap15[i] !== ref15[i]) diff++;
        check_output("scan2_identical", 32'(diff), 32'd0);
        check_output("scan2_p1_1_b0", 32'(cap0[67]), 32'h10);
        count_valid(30, stray);
        check_output("pulse_no_rescan", 32'(stray), 32'd0);

        $display("[TB] scan 3 aborted by reset");
        iStart = 1'b1;
        repeat (150) @(negedge clk);
        check_output("scan3_running", 32'(oValid), 32'h1);
        rstn   = 1'b1;
        iStart = 1'b0;
        @(negedge clk);
        all_or = oDin0 | oDin1 | oDin2 | oDin3 | oDin4 | oDin5 | oDin6 | oDin7 |
                 oDin8 | oDin9 | oDin10 | oDin11 | oDin12 | oDin13 | oDin14 | oDin15;
        check_output("abort_valid", 32'(oValid), 32'h0);
        check_output("abort_done", 32'(oDone), 32'h0);
        check_output("abort_din", 32'(all_or), 32'h0);
        count_valid(2, stray);
        rstn = 1'b0;
        count_valid(40, n_valid);
        check_output("abort_no_valid", 32'(stray + n_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
